// File: rtl/core_pipe_exec_lsu_split_pkg.sv
// Shared types for the execute-stage load/store unit: access sizes, FSM state encoding
// and the access-size-to-byte-count helper.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } lsu_size_t;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE  = 3'd0;
  localparam lsu_state_t ST_REQ0  = 3'd1;
  localparam lsu_state_t ST_RSP0  = 3'd2;
  localparam lsu_state_t ST_REQ1  = 3'd3;
  localparam lsu_state_t ST_RSP1  = 3'd4;
  localparam lsu_state_t ST_DONE  = 3'd5;
  localparam lsu_state_t ST_DRAIN = 3'd6;

  function automatic logic [3:0] size_bytes(input lsu_size_t size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/core_pipe_exec_lsu_split_if.sv
// Split request/response data memory bus; the LSU is the master, the memory the slave.
interface core_pipe_exec_lsu_split_if #(
  parameter int XLEN = 64,
  parameter int AW   = 64
);
  localparam int BW = XLEN / 8;

  logic            dmem_req;
  logic [AW-1:0]   dmem_addr;
  logic            dmem_wen;
  logic [BW-1:0]   dmem_strb;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rsp_valid;
  logic            dmem_err;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_rsp_valid, dmem_err, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_rsp_valid, dmem_err, dmem_rdata
  );

endinterface

// File: rtl/core_pipe_exec_lsu_split_align.sv
// Byte-lane positioning for stores (two-beat strobes/data) and load extraction with
// sign/zero extension from a pair of beats.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int BW  = XLEN / 8,
  localparam int OW  = $clog2(BW)
) (
  input  logic [OW-1:0]   off,
  input  lsu_size_t       size,
  input  logic            sext,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata0,
  input  logic [XLEN-1:0] rdata1,
  output logic [BW-1:0]   strb0,
  output logic [BW-1:0]   strb1,
  output logic [XLEN-1:0] wdata0,
  output logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] ldata
);

  logic [2*BW-1:0]   mask;
  logic [2*XLEN-1:0] wpos;
  logic [XLEN-1:0]   rsh;
  logic              sign;
  int                nb;
  int                lo;

  assign nb = 32'(size_bytes(size));
  assign lo = 32'(off);

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*BW; i++) mask[i] = (i >= lo) && (i < lo + nb);
    wpos = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  end

  assign strb0  = mask[BW-1:0];
  assign strb1  = mask[2*BW-1:BW];
  assign wdata0 = wpos[XLEN-1:0];
  assign wdata1 = wpos[2*XLEN-1:XLEN];

  // rdata1 is zero for single-beat accesses, so the same shift serves both cases
  always_comb begin
    rsh = XLEN'({rdata1, rdata0} >> {off, 3'b000});
    case (size)
      SZ_BYTE: sign = rsh[7];
      SZ_HALF: sign = rsh[15];
      SZ_WORD: sign = rsh[31];
      default: sign = rsh[XLEN-1];
    endcase
    ldata = '0;
    for (int i = 0; i < BW; i++)
      ldata[8*i +: 8] = (i < nb) ? rsh[8*i +: 8] : {8{sext & sign}};
  end

endmodule

// File: rtl/core_pipe_exec_lsu_split.sv
// Execute-stage data memory unit: one op in flight, misaligned accesses crossing a bus
// word become two beats, load realignment/extension, address and bus-error traps.
module core_pipe_exec_lsu_split
  import core_lsu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int AW        = 64,
  parameter bit SPLIT_MIS = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            new_instr,
  input  logic            valid,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            load,
  input  logic            store,
  input  lsu_size_t       size,
  input  logic            sext,
  output logic            ready,
  output logic [XLEN-1:0] rdata,
  output logic            trap_addr,
  output logic            trap_bus,
  core_pipe_exec_lsu_split_if.master dmem
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  lsu_state_t      state;
  logic [AW-1:0]   base_q;
  logic [OW-1:0]   off_q;
  lsu_size_t       size_q;
  logic            sext_q, load_q, store_q, cross_q;
  logic [XLEN-1:0] wdata_q, beat0_q;

  logic [3:0]      nb_in;
  logic [OW-1:0]   off_in;
  logic            mis_in, cross_in, trap_in;
  logic            in_req0, in_req1, in_rsp1;
  logic [BW-1:0]   strb0, strb1;
  logic [XLEN-1:0] wdata0, wdata1, ldata, rd0, rd1;

  // Request decode, evaluated on the inputs while IDLE
  assign nb_in    = size_bytes(size);
  assign off_in   = addr[OW-1:0];
  assign mis_in   = (off_in & (OW'(nb_in) - OW'(1))) != '0;
  assign cross_in = (32'(off_in) + 32'(nb_in)) > BW;
  assign trap_in  = ((XLEN == 32) && (size == SZ_DOUBLE)) || (mis_in && !SPLIT_MIS);

  assign in_req0 = state == ST_REQ0;
  assign in_req1 = state == ST_REQ1;
  assign in_rsp1 = state == ST_RSP1;

  assign rd0 = in_rsp1 ? beat0_q : dmem.dmem_rdata;
  assign rd1 = in_rsp1 ? dmem.dmem_rdata : '0;

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .off    (off_q),
    .size   (size_q),
    .sext   (sext_q),
    .wdata  (wdata_q),
    .rdata0 (rd0),
    .rdata1 (rd1),
    .strb0  (strb0),
    .strb1  (strb1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .ldata  (ldata)
  );

  assign ready           = state == ST_DONE;
  assign dmem.dmem_req   = in_req0 || in_req1;
  assign dmem.dmem_wen   = (in_req0 || in_req1) && store_q;
  assign dmem.dmem_addr  = in_req1 ? base_q + AW'(BW) : (in_req0 ? base_q : '0);
  assign dmem.dmem_strb  = in_req1 ? strb1 : (in_req0 ? strb0 : '0);
  assign dmem.dmem_wdata = in_req1 ? wdata1 : (in_req0 ? wdata0 : '0);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= ST_IDLE;
      trap_addr <= 1'b0;
      trap_bus  <= 1'b0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (valid) begin
          trap_addr <= trap_in;
          trap_bus  <= 1'b0;
          state     <= trap_in ? ST_DONE : ST_REQ0;
        end
        // A grant coinciding with an abort still owes us a response
        ST_REQ0, ST_REQ1: begin
          if (dmem.dmem_gnt)
            state <= new_instr ? ST_DRAIN : (in_req0 ? ST_RSP0 : ST_RSP1);
          else if (new_instr)
            state <= ST_IDLE;
        end
        ST_RSP0, ST_RSP1: begin
          if (dmem.dmem_rsp_valid) begin
            if (new_instr)
              state <= ST_IDLE;
            else if (!in_rsp1 && !dmem.dmem_err && cross_q)
              state <= ST_REQ1;
            else begin
              state    <= ST_DONE;
              trap_bus <= dmem.dmem_err;
              if (load_q) rdata <= ldata;
            end
          end else if (new_instr) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_DRAIN: if (dmem.dmem_rsp_valid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (state == ST_IDLE && valid) begin
      base_q  <= {addr[AW-1:OW], {OW{1'b0}}};
      off_q   <= off_in;
      size_q  <= size;
      sext_q  <= sext;
      load_q  <= load;
      store_q <= store;
      cross_q <= cross_in;
      wdata_q <= wdata;
    end
    if (state == ST_RSP0 && dmem.dmem_rsp_valid) beat0_q <= dmem.dmem_rdata;
  end

endmodule

// File: tb/tb_core_pipe_exec_lsu_split.sv
// Directed bench: a 64-bit splitting instance and a 32-bit trapping instance driven
// through hand-stepped bus handshakes.
module tb_core_pipe_exec_lsu_split;
  import core_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic        a_new, a_valid, a_load, a_store, a_sext;
  logic [63:0] a_addr, a_wdata, a_rdata;
  lsu_size_t   a_size;
  logic        a_ready, a_tra, a_trb;

  logic        b_new, b_valid, b_load, b_store, b_sext;
  logic [31:0] b_addr, b_wdata, b_rdata;
  lsu_size_t   b_size;
  logic        b_ready, b_tra, b_trb;

  core_pipe_exec_lsu_split_if #(.XLEN(64), .AW(64)) a_bus ();
  core_pipe_exec_lsu_split_if #(.XLEN(32), .AW(32)) b_bus ();

  core_pipe_exec_lsu_split #(.XLEN(64), .AW(64), .SPLIT_MIS(1'b1)) dut_a (
    .g_clk(clk), .g_reset(rst), .new_instr(a_new), .valid(a_valid), .addr(a_addr),
    .wdata(a_wdata), .load(a_load), .store(a_store), .size(a_size), .sext(a_sext),
    .ready(a_ready), .rdata(a_rdata), .trap_addr(a_tra), .trap_bus(a_trb),
    .dmem(a_bus.master)
  );

  core_pipe_exec_lsu_split #(.XLEN(32), .AW(32), .SPLIT_MIS(1'b0)) dut_b (
    .g_clk(clk), .g_reset(rst), .new_instr(b_new), .valid(b_valid), .addr(b_addr),
    .wdata(b_wdata), .load(b_load), .store(b_store), .size(b_size), .sext(b_sext),
    .ready(b_ready), .rdata(b_rdata), .trap_addr(b_tra), .trap_bus(b_trb),
    .dmem(b_bus.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_new = 0; a_valid = 0; a_load = 0; a_store = 0; a_sext = 0;
    a_addr = '0; a_wdata = '0; a_size = SZ_BYTE;
    b_new = 0; b_valid = 0; b_load = 0; b_store = 0; b_sext = 0;
    b_addr = '0; b_wdata = '0; b_size = SZ_BYTE;
    a_bus.dmem_gnt = 0; a_bus.dmem_rsp_valid = 0; a_bus.dmem_err = 0; a_bus.dmem_rdata = '0;
    b_bus.dmem_gnt = 0; b_bus.dmem_rsp_valid = 0; b_bus.dmem_err = 0; b_bus.dmem_rdata = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_a_req",   64'(a_bus.dmem_req), 64'd0);
    chk("rst_a_wen",   64'(a_bus.dmem_wen), 64'd0);
    chk("rst_a_traps", 64'({a_tra, a_trb}), 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_a_strb",  64'(a_bus.dmem_strb), 64'd0);
    chk("rst_a_wdata", a_bus.dmem_wdata, 64'd0);
    chk("rst_b_rdata", 64'(b_rdata), 64'd0);
    chk("rst_b_req",   64'(b_bus.dmem_req), 64'd0);

    // lw 0x1004, sext: single beat in upper lanes
    a_valid = 1; a_load = 1; a_size = SZ_WORD; a_addr = 64'h1004; a_sext = 1;
    step();
    a_valid = 0; a_load = 0; a_addr = '0;
    chk("lw_req",  64'(a_bus.dmem_req), 64'd1);
    chk("lw_addr", a_bus.dmem_addr, 64'h1000);
    chk("lw_strb", 64'(a_bus.dmem_strb), 64'hF0);
    chk("lw_wen",  64'(a_bus.dmem_wen), 64'd0);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    chk("lw_req_drop", 64'(a_bus.dmem_req), 64'd0);
    chk("lw_not_ready", 64'(a_ready), 64'd0);
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_rdata = 64'hDEADBEEF_00000000;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("lw_ready", 64'(a_ready), 64'd1);
    chk("lw_rdata", a_rdata, 64'hFFFFFFFF_DEADBEEF);
    chk("lw_traps", 64'({a_tra, a_trb}), 64'd0);
    step();
    chk("lw_ready_pulse", 64'(a_ready), 64'd0);

    // sd 0x1006: two beats
    a_valid = 1; a_store = 1; a_size = SZ_DOUBLE; a_addr = 64'h1006; a_sext = 0;
    a_wdata = 64'h1122334455667788;
    step();
    a_valid = 0; a_store = 0; a_wdata = '0;
    chk("sd_b0_addr",  a_bus.dmem_addr, 64'h1000);
    chk("sd_b0_strb",  64'(a_bus.dmem_strb), 64'hC0);
    chk("sd_b0_wen",   64'(a_bus.dmem_wen), 64'd1);
    chk("sd_b0_wdata", a_bus.dmem_wdata, 64'h7788000000000000);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_rdata = '0;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("sd_b1_req",   64'(a_bus.dmem_req), 64'd1);
    chk("sd_b1_addr",  a_bus.dmem_addr, 64'h1008);
    chk("sd_b1_strb",  64'(a_bus.dmem_strb), 64'h3F);
    chk("sd_b1_wdata", a_bus.dmem_wdata, 64'h0000112233445566);
    chk("sd_b1_wen",   64'(a_bus.dmem_wen), 64'd1);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    a_bus.dmem_rsp_valid = 1;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("sd_ready", 64'(a_ready), 64'd1);
    chk("sd_trap_bus", 64'(a_trb), 64'd0);
    step();

    // lh 0x1007, beat0 error: no beat1
    a_valid = 1; a_load = 1; a_size = SZ_HALF; a_addr = 64'h1007;
    step();
    a_valid = 0; a_load = 0;
    chk("lh_b0_strb", 64'(a_bus.dmem_strb), 64'h80);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_err = 1;
    step();
    a_bus.dmem_rsp_valid = 0; a_bus.dmem_err = 0;
    chk("lh_err_ready", 64'(a_ready), 64'd1);
    chk("lh_trap_bus",  64'(a_trb), 64'd1);
    chk("lh_no_b1_now", 64'(a_bus.dmem_req), 64'd0);
    step();
    chk("lh_no_b1_next", 64'(a_bus.dmem_req), 64'd0);

    // lw at top of address space: beat1 wraps to 0, split load assembly
    a_valid = 1; a_load = 1; a_size = SZ_WORD; a_addr = 64'hFFFFFFFF_FFFFFFFE; a_sext = 0;
    step();
    a_valid = 0; a_load = 0;
    chk("wrap_b0_addr", a_bus.dmem_addr, 64'hFFFFFFFF_FFFFFFF8);
    chk("wrap_b0_strb", 64'(a_bus.dmem_strb), 64'hC0);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_rdata = 64'hAABB0000_00000000;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("wrap_b1_addr", a_bus.dmem_addr, 64'h0);
    chk("wrap_b1_strb", 64'(a_bus.dmem_strb), 64'h03);
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_rdata = 64'h00000000_0000CCDD;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("wrap_ready", 64'(a_ready), 64'd1);
    chk("wrap_rdata", a_rdata, 64'h00000000_CCDDAABB);
    chk("wrap_trap_bus", 64'(a_trb), 64'd0);
    step();

    // new_instr while REQ0: request withdrawn, no ready
    a_valid = 1; a_load = 1; a_size = SZ_WORD; a_addr = 64'h2000;
    step();
    a_valid = 0; a_load = 0;
    chk("abort_req_up", 64'(a_bus.dmem_req), 64'd1);
    a_new = 1;
    step();
    a_new = 0;
    chk("abort_req_drop", 64'(a_bus.dmem_req), 64'd0);
    chk("abort_no_ready", 64'(a_ready), 64'd0);
    step();
    chk("abort_no_ready2", 64'(a_ready), 64'd0);

    // 32-bit, SPLIT_MIS=0: misaligned lw traps without a request
    b_valid = 1; b_load = 1; b_size = SZ_WORD; b_addr = 32'h1002;
    step();
    b_valid = 0; b_load = 0;
    chk("mis_ready", 64'(b_ready), 64'd1);
    chk("mis_trap_addr", 64'(b_tra), 64'd1);
    chk("mis_no_req", 64'(b_bus.dmem_req), 64'd0);
    step();
    chk("mis_ready_pulse", 64'(b_ready), 64'd0);
    chk("mis_no_req2", 64'(b_bus.dmem_req), 64'd0);

    // 32-bit, double size is illegal
    b_valid = 1; b_load = 1; b_size = SZ_DOUBLE; b_addr = 32'h1000;
    step();
    b_valid = 0; b_load = 0;
    chk("ill_ready", 64'(b_ready), 64'd1);
    chk("ill_trap_addr", 64'(b_tra), 64'd1);
    chk("ill_no_req", 64'(b_bus.dmem_req), 64'd0);
    step();

    // stray response while IDLE is ignored
    b_bus.dmem_rsp_valid = 1; b_bus.dmem_err = 1;
    step();
    b_bus.dmem_rsp_valid = 0; b_bus.dmem_err = 0;
    chk("stray_no_ready", 64'(b_ready), 64'd0);
    chk("stray_no_req", 64'(b_bus.dmem_req), 64'd0);

    // new_instr in RSP0 -> drain, response discarded, no ready
    b_valid = 1; b_load = 1; b_size = SZ_WORD; b_addr = 32'h2000;
    step();
    b_valid = 0; b_load = 0;
    chk("drain_req", 64'(b_bus.dmem_req), 64'd1);
    chk("drain_strb", 64'(b_bus.dmem_strb), 64'hF);
    chk("drain_trap_addr_clr", 64'(b_tra), 64'd0);
    b_bus.dmem_gnt = 1;
    step();
    b_bus.dmem_gnt = 0;
    b_new = 1;
    step();
    b_new = 0;
    chk("drain_no_ready", 64'(b_ready), 64'd0);
    chk("drain_no_req", 64'(b_bus.dmem_req), 64'd0);
    b_bus.dmem_rsp_valid = 1; b_bus.dmem_err = 1; b_bus.dmem_rdata = 32'hFFFFFFFF;
    step();
    b_bus.dmem_rsp_valid = 0; b_bus.dmem_err = 0;
    chk("drain_done_no_ready", 64'(b_ready), 64'd0);

    // lbu 0x1003 with a 5-cycle grant stall
    b_valid = 1; b_load = 1; b_size = SZ_BYTE; b_addr = 32'h1003; b_sext = 0;
    step();
    b_valid = 0; b_load = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_held", 64'(b_bus.dmem_req), 64'd1);
      step();
    end
    chk("lbu_req",  64'(b_bus.dmem_req), 64'd1);
    chk("lbu_addr", 64'(b_bus.dmem_addr), 64'h1000);
    chk("lbu_strb", 64'(b_bus.dmem_strb), 64'h8);
    b_bus.dmem_gnt = 1;
    step();
    b_bus.dmem_gnt = 0;
    b_bus.dmem_rsp_valid = 1; b_bus.dmem_rdata = 32'h80000000;
    step();
    b_bus.dmem_rsp_valid = 0;
    chk("lbu_ready", 64'(b_ready), 64'd1);
    chk("lbu_rdata", 64'(b_rdata), 64'h00000080);
    chk("lbu_traps", 64'({b_tra, b_trb}), 64'd0);
    step();
    chk("lbu_ready_pulse", 64'(b_ready), 64'd0);

    // reset mid-operation: outstanding response ignored
    a_valid = 1; a_load = 1; a_size = SZ_WORD; a_addr = 64'h3000;
    step();
    a_valid = 0; a_load = 0;
    a_bus.dmem_gnt = 1;
    step();
    a_bus.dmem_gnt = 0;
    rst = 1;
    step();
    rst = 0;
    chk("midrst_req", 64'(a_bus.dmem_req), 64'd0);
    chk("midrst_ready", 64'(a_ready), 64'd0);
    chk("midrst_rdata", a_rdata, 64'd0);
    a_bus.dmem_rsp_valid = 1; a_bus.dmem_rdata = 64'h1234;
    step();
    a_bus.dmem_rsp_valid = 0;
    chk("midrst_no_ready", 64'(a_ready), 64'd0);
    chk("midrst_rdata_kept", a_rdata, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
